// File: rtl/knn_stream_classifier.sv
// Streaming k-nearest-neighbour classifier: per-feature squared-distance pipeline,
// K-slot sorted neighbour list and a registered majority vote per query.
module knn_stream_classifier #(
  parameter int NUM_FEAT = 4,
  parameter int ATTR_W   = 8,
  parameter int K        = 5,
  parameter int LABEL_W  = 2,
  parameter int IDX_W    = 8,
  parameter int DIST_W   = 2*ATTR_W + $clog2(NUM_FEAT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       query_valid,
  output logic                       query_ready,
  input  logic [NUM_FEAT*ATTR_W-1:0] query_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FEAT*ATTR_W-1:0] in_data,
  input  logic [LABEL_W-1:0]         in_label,
  input  logic [IDX_W-1:0]           in_index,
  input  logic                       in_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [LABEL_W-1:0]         res,
  output logic [IDX_W-1:0]           res_nn_index,
  output logic [DIST_W-1:0]          res_nn_dist,
  output logic [$clog2(K+1)-1:0]     res_count
);
  localparam int VEC_W   = NUM_FEAT*ATTR_W;
  localparam int CNT_W   = $clog2(K+1);
  localparam int NUM_CLS = 1 << LABEL_W;

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, VOTE, DONE} state_t;
  state_t state;

  logic [VEC_W-1:0] q_data;
  logic q_hs, in_hs;

  assign q_hs  = query_valid & query_ready;
  assign in_hs = in_valid & in_ready;

  function automatic logic [DIST_W-1:0] sq_term(input logic [ATTR_W-1:0] a,
                                                input logic [ATTR_W-1:0] b);
    logic [ATTR_W-1:0]   d;
    logic [2*ATTR_W-1:0] dw;
    d  = (a > b) ? a - b : b - a;
    dw = {{ATTR_W{1'b0}}, d};
    return DIST_W'(dw * dw);
  endfunction

  // Distance pipeline: stage f adds the squared difference of attribute f.
  logic [NUM_FEAT-1:0] p_valid;
  logic [DIST_W-1:0]   p_dist  [NUM_FEAT];
  logic [LABEL_W-1:0]  p_label [NUM_FEAT];
  logic [IDX_W-1:0]    p_index [NUM_FEAT];
  logic [VEC_W-1:0]    p_data  [NUM_FEAT];

  logic [NUM_FEAT-1:0] i_valid;
  logic [DIST_W-1:0]   i_dist  [NUM_FEAT];
  logic [LABEL_W-1:0]  i_label [NUM_FEAT];
  logic [IDX_W-1:0]    i_index [NUM_FEAT];
  logic [VEC_W-1:0]    i_data  [NUM_FEAT];
  logic [DIST_W-1:0]   term    [NUM_FEAT];

  always_comb begin
    i_valid[0] = in_hs;
    i_dist[0]  = '0;
    i_label[0] = in_label;
    i_index[0] = in_index;
    i_data[0]  = in_data;
    for (int unsigned f = 1; f < NUM_FEAT; f++) begin
      i_valid[f] = p_valid[f-1];
      i_dist[f]  = p_dist[f-1];
      i_label[f] = p_label[f-1];
      i_index[f] = p_index[f-1];
      i_data[f]  = p_data[f-1];
    end
    for (int unsigned f = 0; f < NUM_FEAT; f++) begin
      term[f] = sq_term(i_data[f][(NUM_FEAT-1-f)*ATTR_W +: ATTR_W],
                        q_data[(NUM_FEAT-1-f)*ATTR_W +: ATTR_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_valid <= '0;
      for (int unsigned f = 0; f < NUM_FEAT; f++) begin
        p_dist[f]  <= '0;
        p_label[f] <= '0;
        p_index[f] <= '0;
        p_data[f]  <= '0;
      end
    end else begin
      p_valid <= i_valid;
      for (int unsigned f = 0; f < NUM_FEAT; f++) begin
        p_dist[f]  <= i_dist[f] + term[f];
        p_label[f] <= i_label[f];
        p_index[f] <= i_index[f];
        p_data[f]  <= i_data[f];
      end
    end
  end

  // Sorted neighbour slots, slot 0 nearest.
  logic [K-1:0]       slot_valid;
  logic [DIST_W-1:0]  slot_dist  [K];
  logic [LABEL_W-1:0] slot_label [K];
  logic [IDX_W-1:0]   slot_index [K];

  logic               new_valid;
  logic [DIST_W-1:0]  new_dist;
  logic [LABEL_W-1:0] new_label;
  logic [IDX_W-1:0]   new_index;

  assign new_valid = p_valid[NUM_FEAT-1];
  assign new_dist  = p_dist[NUM_FEAT-1];
  assign new_label = p_label[NUM_FEAT-1];
  assign new_index = p_index[NUM_FEAT-1];

  // take[] is monotonic because slots are sorted and occupancy is contiguous,
  // so the first set bit is the insertion point and the rest shift down.
  logic [K-1:0]       take;
  logic [K:0]         take_ext;
  logic [K-1:0]       first;
  logic [K-1:0]       sh_valid;
  logic [DIST_W-1:0]  sh_dist  [K];
  logic [LABEL_W-1:0] sh_label [K];
  logic [IDX_W-1:0]   sh_index [K];

  always_comb begin
    for (int unsigned i = 0; i < K; i++) begin
      take[i] = !slot_valid[i] || (new_dist < slot_dist[i]);
    end
    take_ext = {take, 1'b0};
    first    = take & ~take_ext[K-1:0];
    sh_valid[0] = 1'b0;
    sh_dist[0]  = '0;
    sh_label[0] = '0;
    sh_index[0] = '0;
    for (int unsigned i = 1; i < K; i++) begin
      sh_valid[i] = slot_valid[i-1];
      sh_dist[i]  = slot_dist[i-1];
      sh_label[i] = slot_label[i-1];
      sh_index[i] = slot_index[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_valid <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        slot_dist[i]  <= '0;
        slot_label[i] <= '0;
        slot_index[i] <= '0;
      end
    end else if (q_hs) begin
      slot_valid <= '0;
    end else if (new_valid) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (take[i]) begin
          slot_valid[i] <= first[i] ? 1'b1      : sh_valid[i];
          slot_dist[i]  <= first[i] ? new_dist  : sh_dist[i];
          slot_label[i] <= first[i] ? new_label : sh_label[i];
          slot_index[i] <= first[i] ? new_index : sh_index[i];
        end
      end
    end
  end

  // Scanning slots in order with a strict compare makes the tied class owning
  // the lowest slot win.
  logic [CNT_W-1:0]   cls_cnt [NUM_CLS];
  logic [CNT_W-1:0]   occ;
  logic [CNT_W-1:0]   best_cnt;
  logic [LABEL_W-1:0] best_lbl;

  always_comb begin
    occ = '0;
    for (int unsigned c = 0; c < NUM_CLS; c++) cls_cnt[c] = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (slot_valid[i]) begin
        cls_cnt[slot_label[i]] = cls_cnt[slot_label[i]] + CNT_W'(1);
        occ = occ + CNT_W'(1);
      end
    end
    best_cnt = '0;
    best_lbl = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (slot_valid[i] && (cls_cnt[slot_label[i]] > best_cnt)) begin
        best_cnt = cls_cnt[slot_label[i]];
        best_lbl = slot_label[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      query_ready  <= 1'b1;
      in_ready     <= 1'b0;
      res_valid    <= 1'b0;
      res          <= '0;
      res_nn_index <= '0;
      res_nn_dist  <= '0;
      res_count    <= '0;
      q_data       <= '0;
    end else begin
      case (state)
        IDLE: if (q_hs) begin
          q_data      <= query_data;
          query_ready <= 1'b0;
          in_ready    <= 1'b1;
          state       <= STREAM;
        end
        STREAM: if (in_hs && in_last) begin
          in_ready <= 1'b0;
          state    <= DRAIN;
        end
        DRAIN: if (p_valid == '0) state <= VOTE;
        VOTE: begin
          res          <= best_lbl;
          res_nn_index <= slot_index[0];
          res_nn_dist  <= slot_dist[0];
          res_count    <= occ;
          res_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid   <= 1'b0;
          query_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          res_valid   <= 1'b0;
          in_ready    <= 1'b0;
          query_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_stream_classifier.sv
// Randomized and directed bench for knn_stream_classifier against a sort-and-count model.
module tb_knn_stream_classifier;
  localparam int NF = 4, AW = 8, KN = 5, LW = 2, IW = 8, DW = 18, CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic query_valid = 1'b0, query_ready;
  logic [NF*AW-1:0] query_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic [NF*AW-1:0] in_data = '0;
  logic [LW-1:0] in_label = '0;
  logic [IW-1:0] in_index = '0;
  logic in_last = 1'b0;
  logic res_valid, res_ready = 1'b0;
  logic [LW-1:0] res;
  logic [IW-1:0] res_nn_index;
  logic [DW-1:0] res_nn_dist;
  logic [CW-1:0] res_count;

  knn_stream_classifier #(.NUM_FEAT(NF), .ATTR_W(AW), .K(KN), .LABEL_W(LW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .query_valid(query_valid), .query_ready(query_ready), .query_data(query_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_label(in_label), .in_index(in_index), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .res_nn_index(res_nn_index), .res_nn_dist(res_nn_dist), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current query description, consumed by the model and the driver.
  logic [31:0] q_vec;
  logic [31:0] s_data [32];
  int s_label [32];
  int s_index [32];
  int n_s;
  int exp_res, exp_idx, exp_dist, exp_cnt;

  function automatic logic [31:0] all4(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b, b, b, b};
  endfunction

  function automatic int dist_of(input logic [31:0] a, input logic [31:0] b);
    int d, x, y;
    d = 0;
    for (int f = 0; f < NF; f++) begin
      x = int'(a[31-8*f -: 8]);
      y = int'(b[31-8*f -: 8]);
      d += (x - y) * (x - y);
    end
    return d;
  endfunction

  // Stable selection of the K nearest (earlier arrival first on equal distance),
  // then plurality vote with ties going to the class seen first in that order.
  task automatic model();
    int dd [32];
    bit used [32];
    int pick [KN];
    int cnt [4];
    int m, best, mx;
    for (int j = 0; j < n_s; j++) begin
      dd[j] = dist_of(q_vec, s_data[j]);
      used[j] = 0;
    end
    m = (n_s < KN) ? n_s : KN;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < m; k++) begin
      best = -1;
      for (int j = 0; j < n_s; j++)
        if (!used[j] && (best < 0 || dd[j] < dd[best])) best = j;
      used[best] = 1;
      pick[k] = best;
      cnt[s_label[best]]++;
    end
    mx = 0;
    for (int c = 0; c < 4; c++) if (cnt[c] > mx) mx = cnt[c];
    exp_res = -1;
    for (int k = 0; k < m; k++)
      if (exp_res < 0 && cnt[s_label[pick[k]]] == mx) exp_res = s_label[pick[k]];
    exp_idx  = s_index[pick[0]];
    exp_dist = dd[pick[0]];
    exp_cnt  = m;
  endtask

  task automatic start_query();
    int budget;
    budget = 0;
    while (!query_ready && budget < 100) begin step(); budget++; end
    check("query_ready_wait", query_ready, 1);
    query_valid = 1'b1;
    query_data  = q_vec;
    step();
    query_valid = 1'b0;
  endtask

  task automatic send(input int j, input bit last);
    int budget;
    budget = 0;
    while (!in_ready && budget < 100) begin step(); budget++; end
    in_valid = 1'b1;
    in_data  = s_data[j];
    in_label = LW'(s_label[j]);
    in_index = IW'(s_index[j]);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_query(input bit gaps, input int hold);
    int budget, t_last;
    t_last = 0;
    start_query();
    for (int j = 0; j < n_s; j++) begin
      send(j, j == n_s - 1);
      if (j == n_s - 1) t_last = cyc;
      else if (gaps) step();
    end
    model();
    budget = 0;
    while (!res_valid && budget < 50) begin step(); budget++; end
    check("latency", cyc - t_last, NF + 2);
    check("res_valid", res_valid, 1);
    check("res", res, exp_res);
    check("nn_index", res_nn_index, exp_idx);
    check("nn_dist", res_nn_dist, exp_dist);
    check("count", res_count, exp_cnt);
    check("qready_done", query_ready, 0);
    check("inready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", res_valid, 1);
      check("hold_res", res, exp_res);
      check("hold_dist", res_nn_dist, exp_dist);
      check("hold_index", res_nn_index, exp_idx);
      check("hold_qready", query_ready, 0);
      check("hold_inready", in_ready, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("release_valid", res_valid, 0);
    check("release_qready", query_ready, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_qready"}, query_ready, 1);
    check({tag, "_inready"}, in_ready, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_res"}, res, 0);
    check({tag, "_idx"}, res_nn_index, 0);
    check({tag, "_dist"}, res_nn_dist, 0);
    check({tag, "_cnt"}, res_count, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat [6];
    int lab [6];
    bit narrow;
    rst = 1'b0;
    step(); step();
    check_idle_outputs("reset");
    rst = 1'b1;

    // Majority vote, with 10 cycles of backpressure in DONE.
    sat = '{10, 11, 12, 13, 14, 0};
    lab = '{2, 1, 1, 3, 1, 0};
    q_vec = all4(10);
    n_s = 6;
    for (int j = 0; j < 6; j++) begin
      s_data[j] = all4(sat[j]); s_label[j] = lab[j]; s_index[j] = j;
    end
    run_query(0, 10);
    check("t1_res_const", exp_res, 1);

    // Fewer than K, label 0, tie-break to nearest.
    q_vec = all4(10);
    n_s = 2;
    s_data[0] = all4(11);        s_label[0] = 0; s_index[0] = 4;
    s_data[1] = 32'h0A0A0A0B;    s_label[1] = 3; s_index[1] = 9;
    run_query(0, 0);

    // Equal distances keep arrival order.
    lab = '{0, 0, 1, 1, 1, 2};
    n_s = 6;
    for (int j = 0; j < 6; j++) begin
      s_data[j] = all4(10); s_label[j] = lab[j]; s_index[j] = j;
    end
    run_query(0, 2);

    // Extremes, with and without bubbles.
    q_vec = all4(0);
    n_s = 3;
    for (int j = 0; j < 3; j++) begin
      s_data[j] = all4(255); s_label[j] = (j == 1) ? 2 : 1; s_index[j] = 7 + j;
    end
    run_query(1, 0);
    check("ext_dist_gap", res_nn_dist, 260100);
    run_query(0, 0);

    // Reset in the middle of a stream.
    q_vec = all4(5);
    start_query();
    for (int j = 0; j < 3; j++) begin
      s_data[j] = all4(5); s_label[j] = 1; s_index[j] = j;
      send(j, 1'b0);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_idle_outputs("midrst");
    q_vec = all4(0);
    n_s = 1;
    s_data[0] = all4(200); s_label[0] = 2; s_index[0] = 3;
    run_query(0, 0);

    // Randomized queries.
    for (int t = 0; t < 25; t++) begin
      narrow = 1'($urandom_range(0, 1));
      n_s = $urandom_range(1, 12);
      q_vec = narrow ? {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                        8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))} : $urandom;
      for (int j = 0; j < n_s; j++) begin
        s_data[j] = narrow ? {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                              8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))} : $urandom;
        s_label[j] = $urandom_range(0, 3);
        s_index[j] = $urandom_range(0, 255);
      end
      run_query(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/knn_stream_classifier.md
Name: knn_stream_classifier

Overview:
- Parametrised successor of the fixed 4-attribute, 5-NN classifier. Feature count, attribute width, K, class count and index width are all parameters.
- Adds query/sample/result valid-ready handshakes and explicit slot-occupancy tracking, so label 0 is a real class.
- Correct voting when fewer than K training samples are streamed.
- Sits between the training-sample streamer and the result collector: one query vector, then a burst of training samples, then one result.

Parameters:
- NUM_FEAT, 4, attributes per sample (one distance pipeline stage each)
- ATTR_W, 8, unsigned attribute width
- K, 5, neighbours kept (1..15)
- LABEL_W, 2, label width; classes 0..2^LABEL_W-1
- IDX_W, 8, sample index width
- DIST_W, 2*ATTR_W+$clog2(NUM_FEAT) (18), accumulated distance width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low: rst==0 at posedge resets the block
- query_valid  in  1  test vector valid
- query_ready  out  1  block accepts a new test vector
- query_data  in  NUM_FEAT*ATTR_W  test vector; attribute 0 in MSBs
- in_valid  in  1  training sample valid
- in_ready  out  1  block accepts a training sample
- in_data  in  NUM_FEAT*ATTR_W  training vector; attribute 0 in MSBs
- in_label  in  LABEL_W  sample label
- in_index  in  IDX_W  sample index
- in_last  in  1  final sample of the current query
- res_valid  out  1  result valid, held until accepted
- res_ready  in  1  collector accepts result
- res  out  LABEL_W  majority label
- res_nn_index  out  IDX_W  index of the nearest neighbour
- res_nn_dist  out  DIST_W  distance of the nearest neighbour
- res_count  out  $clog2(K+1)  occupied neighbour slots used in the vote

Behaviour:
- Reset (rst==0): FSM goes to IDLE; all pipeline valids, slot valids, slots and result registers clear. Every output reads 0 except query_ready, which is 1 from the first cycle after reset.
- FSM states: IDLE, STREAM, DRAIN, VOTE, DONE.
- IDLE: query_ready=1, in_ready=0. On the query handshake, latch query_data, clear all K slot valids, go to STREAM.
- STREAM: in_ready=1, query_ready=0. Each in handshake launches the sample into the distance pipeline. On a handshake with in_last=1, go to DRAIN. Gaps in in_valid insert bubbles.
- DRAIN: in_ready=0. Stay until every distance-pipeline valid bit is clear and the final insertion has completed, then go to VOTE.
- VOTE: one cycle. Register res, res_nn_index, res_nn_dist and res_count, then go to DONE.
- DONE: res_valid=1 with outputs stable. On res_ready, go to IDLE; query_ready=1 the following cycle.
- Distance is the squared Euclidean distance: the sum over features of (x-y)^2.
  - Stage f adds feature f's term and registers dist, label, index, valid and the remaining attributes.
  - Pipeline latency is NUM_FEAT cycles; throughput is 1 sample/cycle.
  - Accumulation is unsigned at DIST_W with no overflow at defaults (max 4*255^2=260100).
- Sorter: K registered slots, sorted ascending with slot 0 nearest.
  - A valid pipeline output is inserted at the first position p where the slot is empty or new_dist < slot_dist (strict).
  - Slots p..K-2 shift down one place; slot K-1 drops off.
  - A sample with dist >= slot K-1 dist while all slots are full is discarded.
  - Equal distances therefore keep the earlier arrival ahead.
  - One insertion per cycle.
- Vote: count the occupied slots per class; res is the class with the highest count.
  - Tie: the tied class owning the lowest-numbered slot wins.
  - res_count = number of occupied slots, which is min(samples, K).
  - res_nn_* come from slot 0.
- Timing: res_valid rises exactly NUM_FEAT+2 cycles after the in_last handshake edge.
- Reset mid-operation: when rst==0 in any state, the block discards all in-flight samples and the partial result. The next query never observes stale slots.
- A query with a single sample is legal: in_last=1 on the first sample gives res_count=1.

Test Plan:
1. Majority vote:
   - Stimulus: test = {10,10,10,10}; six samples with all attrs 10/11/12/13/14/0, labels 2/1/1/3/1/0, indices 0..5, last on sample 5.
   - Required: res=1, res_nn_index=0, res_nn_dist=0, res_count=5; res_valid exactly 6 cycles after the last handshake.
2. Fewer than K, label-0 class, tie-break:
   - Stimulus: two samples with dist 4 (label 0) and dist 1 (label 3).
   - Required: res=3, res_count=2, res_nn_dist=1.
3. Equal distances:
   - Stimulus: six samples all at dist 0, labels 0,0,1,1,1,2, indices 0..5.
   - Required: slots hold indices 0..4; res=1, res_nn_index=0, res_count=5.
4. Backpressure:
   - Stimulus: hold res_ready=0 for 10 cycles in DONE.
   - Required: res_valid=1 and all outputs stable; query_ready=in_ready=0 throughout.
   - Then pulse res_ready: query_ready=1 next cycle and a new query is accepted.
5. Extremes and bubbles:
   - Stimulus: test all 0; sample all 255 with in_valid toggled every other cycle.
   - Required: res_nn_dist=260100 with no wrap; result identical to the gap-free case.
6. Reset mid-stream:
   - Stimulus: rst=0 for one cycle after 3 samples in STREAM.
   - Required: all outputs 0, query_ready=1 next cycle.
   - Then a fresh 1-sample query (label 2) gives res=2, res_count=1.
